hub75_fb_writer: RTL and testbench

Stream-to-framebuffer writer: the producer side of the HUB75 framebuffer that the scan/shift engine reads. Accepts an RGB888 pixel stream in raster order, packs each pixel to 20-bit 7-7-6 and writes it into the back bank of a double-buffered 256x64 BRAM framebuffer. Swaps banks with the scan engine only on its frame_start pulse, so a frame is never displayed half-written.

---
 rtl/hub75_fb_writer.sv | 141 ++++++++++++++
 tb/tb_hub75_fb_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_writer.sv
// Stream-to-framebuffer writer for a double-buffered HUB75 display: packs RGB888 to 7-7-6
// and writes the back bank, swapping only at the scan engine's frame boundary. Macro HUB75_FB_ROUND_EN selects rounding packing.
module hub75_fb_writer #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 64,
  parameter int XW     = 8,
  parameter int YW     = 6
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [23:0]      s_data,
  input  logic             s_sof,
  input  logic             frame_start,
  output logic             fb_we,
  output logic [YW+XW:0]   fb_waddr,
  output logic [19:0]      fb_wdata,
  output logic             rd_bank,
  output logic             frame_pending,
  output logic             sync_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {WAIT_SOF, WRITE, WAIT_SWAP} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_t            r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_wbank;
  logic              r_we;
  logic [YW+XW:0]    r_waddr;
  logic [19:0]       r_wdata;
  logic              r_pending;
  logic              r_sync_err;
  logic [7:0]        r_err_cnt;
  logic              w_accept;
  logic [19:0]       w_packed;

  function automatic logic [6:0] rnd7(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} + 9'd1;
    return s[8] ? 7'h7F : s[7:1];
  endfunction

  function automatic logic [5:0] rnd6(input logic [7:0] v);
    logic [9:0] s;
    s = {2'b00, v} + 10'd2;
    return s[8] ? 6'h3F : s[7:2];
  endfunction

  function automatic logic [19:0] pack_px(input logic [23:0] d);
`ifdef HUB75_FB_ROUND_EN
    return {rnd7(d[23:16]), rnd7(d[15:8]), rnd6(d[7:0])};
`else
    return {d[23:17], d[15:9], d[7:2]};
`endif
  endfunction

  // Ready depends on state alone so the producer never sees a valid->ready loop.
  assign s_ready       = (r_state != WAIT_SWAP);
  assign w_accept      = s_valid & s_ready;
  assign w_packed      = pack_px(s_data);

  assign fb_we         = r_we;
  assign fb_waddr      = r_waddr;
  assign fb_wdata      = r_wdata;
  assign rd_bank       = ~r_wbank;
  assign frame_pending = r_pending;
  assign sync_err      = r_sync_err;
  assign err_cnt       = r_err_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_SOF;
      r_x        <= '0;
      r_y        <= '0;
      r_wbank    <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_pending  <= 1'b0;
      r_sync_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_we       <= 1'b0;
      r_sync_err <= 1'b0;
      case (r_state)
        WAIT_SOF: begin
          if (w_accept && s_sof) begin
            r_we    <= 1'b1;
            r_waddr <= {r_wbank, {YW{1'b0}}, {XW{1'b0}}};
            r_wdata <= w_packed;
            r_x     <= XW'(1);
            r_y     <= '0;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_wdata <= w_packed;
            if (s_sof && (r_x != '0 || r_y != '0)) begin
              // Resync: restart the frame in the same bank rather than drop the pixel.
              r_sync_err <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_waddr <= {r_wbank, {YW{1'b0}}, {XW{1'b0}}};
              r_x     <= XW'(1);
              r_y     <= '0;
            end else begin
              r_waddr <= {r_wbank, r_y, r_x};
              if (r_x == X_LAST && r_y == Y_LAST) begin
                r_pending <= 1'b1;
                r_x       <= '0;
                r_y       <= '0;
                r_state   <= WAIT_SWAP;
              end else if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_start) begin
            r_wbank   <= ~r_wbank;
            r_pending <= 1'b0;
            r_state   <= WAIT_SOF;
          end
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// Directed bench for hub75_fb_writer: full frame, bank swap, discard, resync and mid-frame reset.
module tb_hub75_fb_writer;
  localparam int WIDTH  = 256;
  localparam int HEIGHT = 64;
  localparam int XW     = 8;
  localparam int YW     = 6;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [23:0]       s_data;
  logic              s_sof;
  logic              frame_start;
  logic              fb_we;
  logic [YW+XW:0]    fb_waddr;
  logic [19:0]       fb_wdata;
  logic              rd_bank;
  logic              frame_pending;
  logic              sync_err;
  logic [7:0]        err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  hub75_fb_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .frame_start(frame_start), .fb_we(fb_we),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .rd_bank(rd_bank),
    .frame_pending(frame_pending), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_pack(input logic [23:0] d);
    int r, g, b;
`ifdef HUB75_FB_ROUND_EN
    r = (int'(d[23:16]) + 1) / 2; if (r > 127) r = 127;
    g = (int'(d[15:8]) + 1) / 2;  if (g > 127) g = 127;
    b = (int'(d[7:0]) + 2) / 4;   if (b > 63)  b = 63;
`else
    r = int'(d[23:16]) / 2;
    g = int'(d[15:8]) / 2;
    b = int'(d[7:0]) / 4;
`endif
    return {r[6:0], g[6:0], b[5:0]};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic sof);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] d;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; frame_start = 1'b0;
    repeat (3) tick();
    check("rst_we", fb_we, 0);
    check("rst_waddr", fb_waddr, 0);
    check("rst_wdata", fb_wdata, 0);
    check("rst_rd_bank", rd_bank, 1);
    check("rst_pending", frame_pending, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_ready", s_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      send(24'h123456 + 24'(i), 1'b0);
      check("discard_we", fb_we, 0);
    end
    send(24'hFF8040, 1'b1);
    check("sof_we", fb_we, 1);
    check("sof_addr", fb_waddr, 0);
    check("sof_data", fb_wdata, {7'h7F, 7'h40, 6'h10});
    send(24'hFFFFFF, 1'b0);
    check("white_addr", fb_waddr, 1);
    check("white_data", fb_wdata, {7'h7F, 7'h7F, 6'h3F});

    for (int i = 2; i < NPIX; i++) begin
      d = 24'($urandom);
      frame_start = (i == 100) || (i == NPIX - 1);
      send(d, 1'b0);
      frame_start = 1'b0;
      check("f0_we", fb_we, 1);
      check("f0_addr", fb_waddr, 32'(i));
      check("f0_data", fb_wdata, model_pack(d));
    end
    check("f0_pending", frame_pending, 1);
    check("f0_ready_low", s_ready, 0);
    check("coincident_fs_no_swap", rd_bank, 1);
    tick();
    check("wait_swap_no_we", fb_we, 0);
    check("wait_swap_pending", frame_pending, 1);
    check("wait_swap_rd_bank", rd_bank, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("swap_rd_bank", rd_bank, 0);
    check("swap_pending", frame_pending, 0);
    check("swap_ready", s_ready, 1);
    check("swap_no_we", fb_we, 0);

    send(24'h204060, 1'b1);
    check("f1_first_we", fb_we, 1);
    check("f1_first_addr", fb_waddr, 32'h4000);
    for (int i = 1; i < 300; i++) begin
      d = 24'($urandom);
      send(d, 1'b0);
      check("f1_addr", fb_waddr, 32'h4000 + 32'(i));
    end
    check("f1_no_err", sync_err, 0);
    send(24'hABCDEF, 1'b1);
    check("resync_err", sync_err, 1);
    check("resync_cnt", err_cnt, 1);
    check("resync_addr", fb_waddr, 32'h4000);
    check("resync_data", fb_wdata, model_pack(24'hABCDEF));
    send(24'h000000, 1'b0);
    check("resync_err_pulse", sync_err, 0);
    check("resync_next_addr", fb_waddr, 32'h4001);
    for (int k = 0; k < 257; k++) begin
      send(24'($urandom), 1'b1);
      if (k == 0)   check("errcnt_2", err_cnt, 2);
      if (k == 253) check("errcnt_255", err_cnt, 255);
    end
    check("errcnt_sat", err_cnt, 255);
    check("errcnt_sat_err", sync_err, 1);
    check("errcnt_sat_addr", fb_waddr, 32'h4000);

    for (int i = 0; i < 16; i++) send(24'($urandom), 1'b0);
    check("x17_addr", fb_waddr, 32'h4010);
    rst_n = 1'b0;
    #1;
    check("midrst_we", fb_we, 0);
    check("midrst_rd_bank", rd_bank, 1);
    check("midrst_pending", frame_pending, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_waddr", fb_waddr, 0);
    tick();
    check("midrst_hold_we", fb_we, 0);
    rst_n = 1'b1;
    send(24'h010203, 1'b1);
    check("post_rst_we", fb_we, 1);
    check("post_rst_addr", fb_waddr, 0);
    check("post_rst_data", fb_wdata, model_pack(24'h010203));
    s_valid = 1'b0;
    s_sof = 1'b0;
    tick();
    check("idle_we", fb_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
